// File: rtl/par_gen_n_if.sv
// Sample-in / frame-out bundle for par_gen_n, plus phase and overflow status.
// slave = splitter side, master = sample source and frame consumer side.
interface par_gen_n_if #(
    parameter int W_IN = 15,
    parameter int N_PH = 6
);
    localparam int CNT_W = $clog2(N_PH);

    logic signed [W_IN-1:0]      data_in;
    logic                        in_valid;
    logic                        sync;
    logic [N_PH*W_IN-1:0]        data_out;
    logic                        out_valid;
    logic                        out_ready;
    logic [CNT_W-1:0]            phase;
    logic                        ovf;
    logic                        ovf_clr;

    modport slave (
        input  data_in, in_valid, sync, out_ready, ovf_clr,
        output data_out, out_valid, phase, ovf
    );

    modport master (
        output data_in, in_valid, sync, out_ready, ovf_clr,
        input  data_out, out_valid, phase, ovf
    );
endinterface

// File: rtl/par_gen_n.sv
// Polyphase splitter: N_PH accepted samples -> one N_PH-lane frame, 1 cycle after the last sample.
// Never stalls the input: a frame completing while the held frame is unconsumed is dropped and sets sticky ovf.
module par_gen_n #(
    parameter int W_IN = 15,
    parameter int N_PH = 6
) (
    input  logic       clk,
    input  logic       rstn,
    par_gen_n_if.slave bus
);
    localparam int CNT_W = $clog2(N_PH);
    localparam logic [CNT_W-1:0] LAST_PH = CNT_W'(N_PH - 1);

    typedef logic [W_IN-1:0]    sample_t;
    typedef sample_t [N_PH-1:0] frame_t;

    frame_t           collect_q, collect_d;
    frame_t           frame_q, frame_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic             ovf_q, ovf_d;

    logic complete;
    logic can_load;

    // A sync-qualified sample always lands in lane 0, so it can never close a frame.
    assign complete = bus.in_valid && !bus.sync && (phase_q == LAST_PH);
    assign can_load = !out_valid_q || bus.out_ready;

    always_comb begin
        collect_d = collect_q;
        phase_d   = phase_q;
        if (bus.in_valid) begin
            if (bus.sync) begin
                collect_d[0] = bus.data_in;
                phase_d      = CNT_W'(1);
            end else begin
                for (int k = 0; k < N_PH; k++) begin
                    if (phase_q == CNT_W'(k)) begin
                        collect_d[k] = bus.data_in;
                    end
                end
                phase_d = complete ? '0 : phase_q + CNT_W'(1);
            end
        end else if (bus.sync) begin
            phase_d = '0;
        end
    end

    always_comb begin
        frame_d     = frame_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        // Clear is applied first so a drop in the same cycle wins.
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (complete) begin
            if (can_load) begin
                frame_d     = collect_d;
                out_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            collect_q   <= '0;
            frame_q     <= '0;
            out_valid_q <= 1'b0;
            phase_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            collect_q   <= collect_d;
            frame_q     <= frame_d;
            out_valid_q <= out_valid_d;
            phase_q     <= phase_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.data_out  = frame_q;
    assign bus.out_valid = out_valid_q;
    assign bus.phase     = phase_q;
    assign bus.ovf       = ovf_q;

    a_hold_frame: assert property (@(posedge clk) disable iff (!rstn)
        (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(frame_q)));

    a_phase_range: assert property (@(posedge clk) disable iff (!rstn)
        phase_q <= LAST_PH);
endmodule

// File: tb/tb_par_gen_n.sv
// Bench for par_gen_n: vector table plus hand sequences on N_PH=6/W_IN=15, reset check on N_PH=2 and 16.
// Frames are checked through an expected-frame queue popped on each out_valid && out_ready.
module tb_par_gen_n;
    localparam int W  = 15;
    localparam int N  = 6;
    localparam int WB = 8;
    localparam int NB = 2;
    localparam int NC = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    par_gen_n_if #(.W_IN(W),  .N_PH(N))  a ();
    par_gen_n_if #(.W_IN(WB), .N_PH(NB)) b ();
    par_gen_n_if #(.W_IN(WB), .N_PH(NC)) c ();

    par_gen_n #(.W_IN(W),  .N_PH(N))  u_a (.clk(clk), .rstn(rstn), .bus(a.slave));
    par_gen_n #(.W_IN(WB), .N_PH(NB)) u_b (.clk(clk), .rstn(rstn), .bus(b.slave));
    par_gen_n #(.W_IN(WB), .N_PH(NC)) u_c (.clk(clk), .rstn(rstn), .bus(c.slave));

    int checks = 0;
    int errors = 0;
    logic [N*W-1:0] exp_q[$];

    typedef struct {
        logic       iv;
        logic       sy;
        int         din;
        logic       push;
        int         pbase;
        int         pdir;
        logic [2:0] ph;
        logic       ov;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] seq_frame(input int base, input int dir);
        logic [N*W-1:0] f;
        f = '0;
        for (int k = 0; k < N; k++) f[k*W +: W] = W'(base + dir * k);
        return f;
    endfunction

    function automatic logic [127:0] frame8(input int n, input int base);
        logic [127:0] f;
        f = '0;
        for (int k = 0; k < n; k++) f[k*8 +: 8] = 8'(base + k);
        return f;
    endfunction

    task automatic drv(input logic iv, input logic sy, input int d, input logic rdy, input logic clr);
        a.in_valid  = iv;
        a.sync      = sy;
        a.data_in   = W'(d);
        a.out_ready = rdy;
        a.ovf_clr   = clr;
    endtask

    // The consumer takes a frame at the next rising edge whenever valid and ready are both high.
    task automatic tick();
        @(negedge clk);
        if (rstn && a.out_valid && a.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got frame %0h expected none", a.data_out);
            end else begin
                chk("sb_frame", 128'(a.data_out), 128'(exp_q.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic iv, input logic sy, input int din, input logic push,
                        input int pbase, input int pdir, input logic [2:0] ph, input logic ov);
        vec_t v;
        v.iv = iv; v.sy = sy; v.din = din; v.push = push;
        v.pbase = pbase; v.pdir = pdir; v.ph = ph; v.ov = ov;
        vt.push_back(v);
    endtask

    initial begin
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0);
        b.in_valid = 1'b0; b.sync = 1'b0; b.data_in = '0; b.out_ready = 1'b0; b.ovf_clr = 1'b0;
        c.in_valid = 1'b0; c.sync = 1'b0; c.data_in = '0; c.out_ready = 1'b0; c.ovf_clr = 1'b0;

        // Stream 1..12, gapped negatives, then sync realignment.
        for (int i = 1; i <= 12; i++) addv(1'b1, 1'b0, i, i % 6 == 0, i - 5, 1, 3'(i % 6), i % 6 == 0);
        addv(1'b0, 1'b0, 0, 1'b0, 0, 0, 3'd0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            addv(1'b1, 1'b0, -i, i == 6, -1, -1, 3'(i % 6), i == 6);
            addv(1'b0, 1'b0, 0, 1'b0, 0, 0, 3'(i % 6), 1'b0);
        end
        for (int i = 0; i < 3; i++) addv(1'b1, 1'b0, 50 + i, 1'b0, 0, 0, 3'(i + 1), 1'b0);
        addv(1'b1, 1'b1, 100, 1'b0, 0, 0, 3'd1, 1'b0);
        for (int i = 1; i <= 5; i++) addv(1'b1, 1'b0, 100 + i, i == 5, 100, 1, 3'((i + 1) % 6), i == 5);
        addv(1'b0, 1'b0, 0, 1'b0, 0, 0, 3'd0, 1'b0);
        addv(1'b1, 1'b0, 1, 1'b0, 0, 0, 3'd1, 1'b0);
        addv(1'b1, 1'b0, 2, 1'b0, 0, 0, 3'd2, 1'b0);
        addv(1'b0, 1'b1, 0, 1'b0, 0, 0, 3'd0, 1'b0);

        #3;
        chk("rst_phase", 128'(a.phase), 128'(0));
        chk("rst_valid", 128'(a.out_valid), 128'(0));
        chk("rst_ovf", 128'(a.ovf), 128'(0));
        chk("rst_data", 128'(a.data_out), 128'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;

        foreach (vt[i]) begin
            drv(vt[i].iv, vt[i].sy, vt[i].din, 1'b1, 1'b0);
            if (vt[i].push) exp_q.push_back(seq_frame(vt[i].pbase, vt[i].pdir));
            tick();
            chk($sformatf("vec%0d_phase", i), 128'(a.phase), 128'(vt[i].ph));
            chk($sformatf("vec%0d_valid", i), 128'(a.out_valid), 128'(vt[i].ov));
            chk($sformatf("vec%0d_ovf", i), 128'(a.ovf), 128'(0));
        end

        // Backpressure: frame A held, frame B dropped with a coincident ovf_clr.
        for (int i = 1; i <= 6; i++) begin
            drv(1'b1, 1'b0, i, 1'b0, 1'b0);
            if (i == 6) exp_q.push_back(seq_frame(1, 1));
            tick();
        end
        chk("bp_hold_valid", 128'(a.out_valid), 128'(1));
        for (int i = 7; i <= 12; i++) begin
            drv(1'b1, 1'b0, i, 1'b0, i == 12);
            tick();
            if (i == 11) chk("bp_ovf_pre", 128'(a.ovf), 128'(0));
        end
        chk("bp_ovf_set_wins", 128'(a.ovf), 128'(1));
        chk("bp_data_held", 128'(a.data_out), 128'(seq_frame(1, 1)));
        chk("bp_phase", 128'(a.phase), 128'(0));
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("bp_valid_drop", 128'(a.out_valid), 128'(0));
        chk("bp_ovf_sticky", 128'(a.ovf), 128'(1));
        drv(1'b0, 1'b0, 0, 1'b1, 1'b1);
        tick();
        chk("bp_ovf_clr", 128'(a.ovf), 128'(0));

        // Handshake of the held frame on the very cycle the next frame completes.
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, 1'b0, 20 + i, 1'b0, 1'b0);
            if (i == 5) exp_q.push_back(seq_frame(20, 1));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 1'b0, 30 + i, 1'b0, 1'b0);
            tick();
        end
        chk("sim_pre_valid", 128'(a.out_valid), 128'(1));
        drv(1'b1, 1'b0, 35, 1'b1, 1'b0);
        exp_q.push_back(seq_frame(30, 1));
        tick();
        chk("sim_valid", 128'(a.out_valid), 128'(1));
        chk("sim_data", 128'(a.data_out), 128'(seq_frame(30, 1)));
        chk("sim_ovf", 128'(a.ovf), 128'(0));
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();
        chk("sim_valid_drop", 128'(a.out_valid), 128'(0));

        // Reset mid-frame with a held frame and ovf set.
        for (int i = 0; i < 16; i++) begin
            drv(1'b1, 1'b0, 40 + i, 1'b0, 1'b0);
            if (i == 5) exp_q.push_back(seq_frame(40, 1));
            tick();
        end
        chk("mid_pre_ovf", 128'(a.ovf), 128'(1));
        chk("mid_pre_phase", 128'(a.phase), 128'(4));
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_data", 128'(a.data_out), 128'(0));
        chk("arst_valid", 128'(a.out_valid), 128'(0));
        chk("arst_phase", 128'(a.phase), 128'(0));
        chk("arst_ovf", 128'(a.ovf), 128'(0));
        exp_q.delete();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drv(1'b1, 1'b0, 9 + i, 1'b1, 1'b0);
            if (i == 5) exp_q.push_back(seq_frame(9, 1));
            tick();
        end
        chk("post_rst_valid", 128'(a.out_valid), 128'(1));
        chk("post_rst_data", 128'(a.data_out), 128'(seq_frame(9, 1)));
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0);
        tick();

        // Same reset scenario on the N_PH=2 and N_PH=16 instances.
        for (int i = 0; i < 36; i++) begin
            b.in_valid = (i < 5);
            b.data_in  = WB'(i + 1);
            c.in_valid = 1'b1;
            c.data_in  = WB'(i + 1);
            tick();
        end
        b.in_valid = 1'b0;
        c.in_valid = 1'b0;
        chk("n2_pre_ovf", 128'(b.ovf), 128'(1));
        chk("n2_pre_phase", 128'(b.phase), 128'(1));
        chk("n2_pre_data", 128'(b.data_out), frame8(NB, 1));
        chk("n16_pre_ovf", 128'(c.ovf), 128'(1));
        chk("n16_pre_phase", 128'(c.phase), 128'(4));
        chk("n16_pre_data", 128'(c.data_out), frame8(NC, 1));
        #2;
        rstn = 1'b0;
        #1;
        chk("n2_arst_data", 128'(b.data_out), 128'(0));
        chk("n2_arst_valid", 128'(b.out_valid), 128'(0));
        chk("n2_arst_ovf", 128'(b.ovf), 128'(0));
        chk("n16_arst_data", 128'(c.data_out), 128'(0));
        chk("n16_arst_phase", 128'(c.phase), 128'(0));
        chk("n16_arst_ovf", 128'(c.ovf), 128'(0));
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            b.in_valid = (i < 2);
            b.data_in  = WB'(9 + i);
            c.in_valid = 1'b1;
            c.data_in  = WB'(9 + i);
            tick();
        end
        b.in_valid = 1'b0;
        c.in_valid = 1'b0;
        chk("n2_valid", 128'(b.out_valid), 128'(1));
        chk("n2_data", 128'(b.data_out), frame8(NB, 9));
        chk("n2_phase", 128'(b.phase), 128'(0));
        chk("n16_valid", 128'(c.out_valid), 128'(1));
        chk("n16_data", 128'(c.data_out), frame8(NC, 9));
        chk("n16_ovf", 128'(c.ovf), 128'(0));

        chk("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/par_gen_n.md
# par_gen_n

Parametrised serial-to-parallel polyphase splitter for the DWT FIR datapath. It collects N_PH consecutive accepted input samples into one frame and presents the frame as N_PH parallel lanes, so phase k of frame m is sample N_PH·m+k. It sits between the sample source and the N_PH-phase polyphase FIR. It adds an input qualifier, phase resynchronisation, an output valid/ready handshake with a held frame, and a sticky overflow flag.

## Interface
- W_IN, 15, sample width (signed, two's complement), 2..32
- N_PH, 6, phases per frame, 2..16
- CNT_W, $clog2(N_PH), phase counter width (derived, not overridden)
- clk  in  1  rising-edge clock
- rstn  in  1  reset, asynchronous, active-low
- data_in  in  W_IN  signed input sample
- in_valid  in  1  data_in accepted this cycle when high
- sync  in  1  phase realign: restart frame collection
- data_out  out  N_PH·W_IN  frame; lane k = data_out[k·W_IN +: W_IN] = phase k (sample N_PH·m+k)
- out_valid  out  1  data_out holds a complete, unconsumed frame
- out_ready  in  1  consumer takes frame when out_valid && out_ready
- phase  out  CNT_W  index the next accepted sample will occupy
- ovf  out  1  sticky: a completed frame was dropped
- ovf_clr  in  1  clears ovf

## Operation
- Reset (rstn low, async): collect buffer, data_out, out_valid, phase, ovf all 0. Deassertion is synchronous to clk by upstream.
- Collection: on accepted sample (in_valid=1), data_in is written to collect lane phase; phase increments, wrapping N_PH-1 → 0. in_valid=0: nothing changes.
- sync=1 && in_valid=1: sample written to lane 0, phase ← 1; earlier partial frame discarded.
- sync=1 && in_valid=0: phase ← 0; partial frame discarded.
- sync has no effect on the held output frame, out_valid, or ovf.
- Frame completion: an accepted sample with phase = N_PH-1 (and sync=0) completes the frame.
  - If out_valid=0, or out_valid && out_ready in the same cycle: the full frame (including this sample) loads into data_out, and out_valid=1 next cycle.
  - Otherwise (out_valid && !out_ready): the new frame is dropped, data_out is unchanged, and ovf ← 1.
- N_PH=… edge: if sync=1 and in_valid=1, the sample is lane 0, so a frame completes only when N_PH samples follow sync. No partial frame is ever output.
- Handshake: out_valid && out_ready with no completion in that cycle → out_valid ← 0. data_out keeps its last value; it is only ever updated on a load.
- ovf: set on drop, cleared by ovf_clr. A simultaneous set and clear leaves ovf=1.
- Arithmetic: none. Samples pass bit-exact; no sign extension or truncation.

## Timing
- Latency: the last sample of a frame accepted at edge t → data_out/out_valid valid after edge t+1 (1 cycle). Lanes 0..N_PH-1 update in the same cycle.
- Throughput: one frame per N_PH accepted samples. With in_valid held high and out_ready high, out_valid pulses for 1 cycle every N_PH cycles.
- out_valid never drops without a handshake. data_out is stable while out_valid=1 && out_ready=0.
- phase is registered and reflects state after the last edge. ovf is asserted the cycle after the drop.
- Reset mid-frame clears everything immediately. The first sample after reset is lane 0.

## Test plan
- N_PH=6, W_IN=15, out_ready=1, in_valid=1, data_in=1,2,3,…,12 → out_valid pulses one cycle after the 6th and 12th samples. The lanes read (1..6) and then (7..12), lane 0 = 1 and 7 respectively; phase sequence is 0..5,0.
- Gapped input: in_valid toggling 1,0,1,0…, samples −1,−2,…,−6 (0x7FFF, 0x7FFE …) → one frame with lane k = −(k+1) bit-exact. out_valid comes 1 cycle after the 6th accepted sample; idle cycles do not advance phase.
- Backpressure: out_ready=0 after frame A (1..6) is held, then a second frame 7..12 streams in → data_out stays at 1..6, ovf=1 the cycle after the 12th sample. out_ready=1 → out_valid drops; ovf_clr → ovf=0.
- Simultaneous handshake and completion: out_valid=1 with out_ready=1 exactly on the cycle the 6th sample of frame B arrives → out_valid stays 1, data_out = frame B, ovf stays 0.
- sync: feed 3 samples, then sync=1 with sample 100, then 101..105 → frame lanes = 100..105, with the earlier 3 samples absent. Also sync=1, in_valid=0 mid-frame → phase=0.
- Reset mid-frame after 4 samples while a frame is held with ovf=1 → all outputs 0 asynchronously. Next 6 samples 9..14 → frame 9..14. Repeat with N_PH=2 and N_PH=16, W_IN=8.
